// File: rtl/mix_columns_enc_iter.sv
// Iterative forward AES MixColumns: transforms COLS_PER_CYCLE columns per cycle in place,
// with valid/ready on both sides and a bypass path for the final round.
module mix_columns_enc_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Din,
  input  logic         i_Bypass,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [127:0] o_Dout
);

  // With four columns per cycle the step truncates to 0 and the counter never moves.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [2:0] SPAN     = 3'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         bypass_q, bypass_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] mixed;
  logic [127:0] col_mask;
  logic [3:0]   col_sel;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Column gi is rewritten when it falls in the window [cnt, cnt+COLS_PER_CYCLE).
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign mixed[127-32*gi -: 32]    = mix_col(dout_q[127-32*gi -: 32]);
    assign col_sel[gi]               = (3'(gi) >= {1'b0, cnt_q}) &&
                                       (3'(gi) < ({1'b0, cnt_q} + SPAN)) && !bypass_q;
    assign col_mask[127-32*gi -: 32] = {32{col_sel[gi]}};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bypass_d = bypass_q;
    dout_d   = dout_q;
    case (state_q)
      IDLE: begin
        if (i_Valid) begin
          dout_d   = i_Din;
          bypass_d = i_Bypass;
          cnt_d    = 2'd0;
          state_d  = i_Bypass ? DONE : BUSY;
        end
      end
      BUSY: begin
        dout_d = (mixed & col_mask) | (dout_q & ~col_mask);
        cnt_d  = cnt_q + STEP;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_Ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      bypass_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bypass_q <= bypass_d;
      dout_q   <= dout_d;
    end
  end

  assign o_Ready = (state_q == IDLE);
  assign o_Valid = (state_q == DONE);
  assign o_Dout  = dout_q;

endmodule

// File: tb/tb_mix_columns_enc_iter.sv
// Directed and random checks of the iterative MixColumns engine at 1, 2 and 4 columns per cycle.
module tb_mix_columns_enc_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [127:0] i_din;
  logic         i_bypass;
  logic         i_ready;
  logic         o_ready, o_valid;
  logic [127:0] o_dout;
  logic         o_ready2, o_valid2;
  logic [127:0] o_dout2;
  logic         o_ready4, o_valid4;
  logic [127:0] o_dout4;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COL1_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] COL1_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] COL2_IN  = 128'hd4d4d4d52d26314c00000000ffffffff;
  localparam logic [127:0] COL2_OUT = 128'hd5d5d7d64d7ebdf800000000ffffffff;
  localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  mix_columns_enc_iter #(.COLS_PER_CYCLE(1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(i_valid), .o_Ready(o_ready), .i_Din(i_din),
    .i_Bypass(i_bypass), .o_Valid(o_valid), .i_Ready(i_ready), .o_Dout(o_dout));

  mix_columns_enc_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(i_valid), .o_Ready(o_ready2), .i_Din(i_din),
    .i_Bypass(i_bypass), .o_Valid(o_valid2), .i_Ready(i_ready), .o_Dout(o_dout2));

  mix_columns_enc_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(i_valid), .o_Ready(o_ready4), .i_Din(i_din),
    .i_Bypass(i_bypass), .o_Valid(o_valid4), .i_Ready(i_ready), .o_Dout(o_dout4));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant-matrix model; inv selects the InvMixColumns coefficients.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0]   m[4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-32*c-8*j -: 8], m[(j - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Presents one state and returns 1 ns after the accepting edge.
  task automatic send(input logic [127:0] d, input logic byp);
    int waited = 0;
    @(negedge clk);
    i_valid  = 1'b1;
    i_din    = d;
    i_bypass = byp;
    while (o_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (o_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: o_Ready=%b required 1", o_ready);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (o_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic handoff;
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_din = '0; i_bypass = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", o_valid); end
    n_cmp++; if (o_dout !== 128'h0) begin n_err++; $display("FAIL reset_dout: got %h required 0", o_dout); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", o_ready); end
    n_cmp++; if ({o_valid2, o_valid4} !== 2'b00) begin n_err++; $display("FAIL reset_valid_wide: got %b required 00", {o_valid2, o_valid4}); end
    $display("reset: done");
  endtask

  task automatic test_latency;
    send(FIPS_IN, 1'b0);
    for (int e = 0; e <= 4; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      n_cmp++;
      if ({o_valid, o_valid2, o_valid4} !== {e >= 4, e >= 2, e >= 1}) begin
        n_err++;
        $display("FAIL latency_edge%0d: valid(1,2,4)=%b required %b", e,
                 {o_valid, o_valid2, o_valid4}, {e >= 4, e >= 2, e >= 1});
      end
    end
    n_cmp++; if (o_dout !== FIPS_OUT) begin n_err++; $display("FAIL fips_p1: got %h required %h", o_dout, FIPS_OUT); end
    n_cmp++; if (o_dout2 !== FIPS_OUT) begin n_err++; $display("FAIL fips_p2: got %h required %h", o_dout2, FIPS_OUT); end
    n_cmp++; if (o_dout4 !== FIPS_OUT) begin n_err++; $display("FAIL fips_p4: got %h required %h", o_dout4, FIPS_OUT); end
    handoff();
    $display("latency: fips vector out=%h", o_dout);
  endtask

  task automatic test_columns;
    logic [127:0] vin[2];
    logic [127:0] vout[2];
    int edges;
    vin  = '{COL1_IN, COL2_IN};
    vout = '{COL1_OUT, COL2_OUT};
    for (int i = 0; i < 2; i++) begin
      send(vin[i], 1'b0);
      wait_done(edges);
      n_cmp++; if (edges != 4) begin n_err++; $display("FAIL col%0d_latency: got %0d required 4", i, edges); end
      n_cmp++; if (o_dout !== vout[i]) begin n_err++; $display("FAIL col%0d_dout: got %h required %h", i, o_dout, vout[i]); end
      handoff();
      n_cmp++; if ({o_valid, o_ready} !== 2'b01) begin n_err++; $display("FAIL col%0d_handoff: valid,ready=%b required 01", i, {o_valid, o_ready}); end
      $display("columns: in=%h out=%h", vin[i], o_dout);
    end
  endtask

  task automatic test_bypass;
    int edges;
    send(BYP_IN, 1'b1);
    wait_done(edges);
    n_cmp++; if (edges != 0) begin n_err++; $display("FAIL bypass_latency: got %0d required 0", edges); end
    n_cmp++; if (o_dout !== BYP_IN) begin n_err++; $display("FAIL bypass_dout: got %h required %h", o_dout, BYP_IN); end
    handoff();
    $display("bypass: in=%h out=%h", BYP_IN, o_dout);
    send(FIPS_IN, 1'b0);
    wait_done(edges);
    n_cmp++; if (edges != 4) begin n_err++; $display("FAIL post_bypass_latency: got %0d required 4", edges); end
    n_cmp++; if (o_dout !== FIPS_OUT) begin n_err++; $display("FAIL post_bypass_dout: got %h required %h", o_dout, FIPS_OUT); end
    handoff();
    $display("bypass: following normal state out=%h", o_dout);
  endtask

  task automatic test_backpressure;
    int edges;
    send(COL1_IN, 1'b0);
    wait_done(edges);
    @(negedge clk);
    i_valid = 1'b1; i_din = COL2_IN; i_bypass = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_valid, o_ready} !== 2'b10 || o_dout !== COL1_OUT) begin
        n_err++;
        $display("FAIL hold_cycle%0d: valid,ready=%b dout=%h required 10 %h", c, {o_valid, o_ready}, o_dout, COL1_OUT);
      end
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    n_cmp++; if ({o_valid, o_ready} !== 2'b01) begin n_err++; $display("FAIL release: valid,ready=%b required 01", {o_valid, o_ready}); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL pending_accept: o_Ready=%b required 0", o_ready); end
    wait_done(edges);
    n_cmp++; if (edges != 4) begin n_err++; $display("FAIL pending_latency: got %0d required 4", edges); end
    n_cmp++; if (o_dout !== COL2_OUT) begin n_err++; $display("FAIL pending_dout: got %h required %h", o_dout, COL2_OUT); end
    handoff();
    $display("backpressure: held 10 cycles, pending out=%h", o_dout);
  endtask

  task automatic test_reset_mid;
    int edges;
    send(FIPS_IN, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b required 0", o_valid); end
    n_cmp++; if (o_dout !== 128'h0) begin n_err++; $display("FAIL midreset_dout: got %h required 0", o_dout); end
    @(negedge clk); rst = 1'b0;
    send(COL1_IN, 1'b0);
    wait_done(edges);
    n_cmp++; if (edges != 4) begin n_err++; $display("FAIL after_reset_latency: got %0d required 4", edges); end
    n_cmp++; if (o_dout !== COL1_OUT) begin n_err++; $display("FAIL after_reset_dout: got %h required %h", o_dout, COL1_OUT); end
    handoff();
    $display("reset_mid: fresh vector out=%h", o_dout);
  endtask

  task automatic test_back_to_back;
    logic [127:0] q_in[$];
    bit           q_byp[$];
    logic [127:0] exp_v, src;
    bit           byp, acc;
    int sent = 0, rcvd = 0, cyc = 0;
    while (rcvd < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      acc = 1'b0;
      if (!i_valid && sent < 1000 && $urandom_range(3) != 0) begin
        i_valid  = 1'b1;
        i_din    = {$urandom, $urandom, $urandom, $urandom};
        i_bypass = ($urandom_range(7) == 0);
      end
      i_ready = ($urandom_range(2) != 0);
      if (o_valid === 1'b1 && i_ready) begin
        if (q_in.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL stream_unexpected: dout=%h with no state pending", o_dout);
        end else begin
          src = q_in.pop_front();
          byp = q_byp.pop_front();
          exp_v = byp ? src : mix_model(src, 1'b0);
          n_cmp++;
          if (o_dout !== exp_v) begin
            n_err++;
            $display("FAIL stream_dout#%0d: got %h required %h", rcvd, o_dout, exp_v);
          end
          if (!byp) begin
            n_cmp++;
            if (mix_model(o_dout, 1'b1) !== src) begin
              n_err++;
              $display("FAIL stream_inverse#%0d: got %h required %h", rcvd, mix_model(o_dout, 1'b1), src);
            end
          end
        end
        rcvd++;
      end
      if (o_ready === 1'b1 && i_valid) begin
        q_in.push_back(i_din);
        q_byp.push_back(i_bypass);
        sent++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) i_valid = 1'b0;
    end
    i_valid = 1'b0; i_ready = 1'b0;
    n_cmp++;
    if (rcvd != 1000) begin n_err++; $display("FAIL stream_count: got %0d required 1000", rcvd); end
    $display("back_to_back: sent=%0d received=%0d cycles=%0d", sent, rcvd, cyc);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_columns();
    test_bypass();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
